rand_word_assembler: RTL and testbench
======================================

// Module: rand_word_assembler
// PURPOSE
// - CPU-side consumer downstream of the TRNG top; drives rand_req/rand_req_type and collects rand_byte words.
// - Packs the words into a 16/32/64-bit result and hands it to the host with a valid pulse.
// - Enforces the served-word limit per request: 1/2/4 words for 16/32/64-bit requests.
// - Excess words, and requests that never complete, are flagged as errors.
// PARAMETERS
// - OUTPUT_WIDTH    16    width of one rand_byte word (params::OUTPUT_WIDTH).
// - MAX_WORDS       4     words per 64-bit request; result width = OUTPUT_WIDTH*MAX_WORDS.
// - TIMEOUT_CYCLES  4096  ic_clk cycles without an accepted word before the request is abandoned.
// PORTS
// - ic_clk             in   1                    sole clock.
// - rst                in   1                    asynchronous reset, active-high.
// - cpu_req            in   1                    start pulse; sampled in IDLE only.
// - cpu_req_type       in   rand_req_t           le_types::rand_req_t; RDSEED/RDRAND x 16/32/64.
// - rand_req           out  1                    request to TRNG top.
// - rand_req_type      out  rand_req_t           latched copy of cpu_req_type.
// - rand_byte          in   OUTPUT_WIDTH         word from TRNG top.
// - rand_valid         in   1                    word-valid from TRNG top.
// - slow_clk           in   1                    TRNG word strobe; treated as data, not as a clock.
// - busy               out  1                    high in every state except IDLE.
// - result             out  OUTPUT_WIDTH*MAX_WORDS  assembled value; bits above the request width are 0.
// - result_valid       out  1                    1-cycle pulse when result is complete.
// - timeout_err        out  1                    1-cycle pulse when a request is abandoned.
// - excess_err         out  1                    sticky; cleared by err_clr.
// - err_clr            in   1                    clears excess_err.
// BEHAVIOUR
// Reset
// - All outputs 0; FSM in IDLE; all counters 0.
// - Asserting rst mid-request aborts it: rand_req drops, no result_valid pulse.
// Sampling of slow_clk, rand_valid and rand_byte
// - slow_clk passes a 2-flop synchroniser plus an edge-detect flop.
// - word_stb is high for 1 ic_clk cycle, 3 cycles after each slow_clk rise.
// - rand_valid is sampled through a matching 2-flop path.
// - rand_byte is captured when word_stb && rand_valid_sync; it must be stable >= 4 ic_clk cycles after the slow_clk rise.
// - Accepted word = word_stb && rand_valid_sync.
// FSM: IDLE -> COLLECT -> DONE -> IDLE
// - IDLE
//   - cpu_req=1: latch type, set target = 1/2/4 words, clear result, word_cnt and timer; go to COLLECT next cycle.
// - COLLECT
//   - rand_req=1.
//   - Accepted word is written to result[word_cnt*OUTPUT_WIDTH +: OUTPUT_WIDTH]; the first word lands in the LSBs.
//   - word_cnt increments; the timer resets.
//   - On the word that makes word_cnt==target, go to DONE.
// - DONE
//   - Lasts 1 cycle: rand_req=0, result_valid=1; then IDLE.
//   - result holds its value until the next cpu_req.
// - Timeout
//   - The timer counts in COLLECT only.
//   - When it reaches TIMEOUT_CYCLES-1 with no accepted word: timeout_err pulses, rand_req drops, go to IDLE.
//   - result keeps the partial words; result_valid is not asserted.
// - Simultaneous timer expiry and accepted word: the word wins and the timer resets.
// Excess words
// - An accepted word while in IDLE or DONE sets excess_err; the word is discarded and result is untouched.
// - err_clr and an excess word in the same cycle: set wins.
// - cpu_req outside IDLE is ignored; busy tells the host to hold off.
// Width and counters
// - word_cnt is $clog2(MAX_WORDS+1) bits.
// - The timer is $clog2(TIMEOUT_CYCLES) bits and has no wrap-around path (it leaves COLLECT first).
// CONFIGURATION
// - Macro RAND_ASM_STATS_EN adds outputs stat_done[31:0], stat_timeout[31:0] and stat_excess[31:0].
//   - Each counts result_valid pulses, timeout_err pulses or excess words respectively.
//   - Each saturates at 32'hFFFF_FFFF and is cleared only by rst.
// - Macro undefined: these ports and counters do not exist; all other behaviour is identical.
// TESTING
// - RDSEED_16, TRNG serves 16'hA5A5 on one strobe:
//   - result = 64'h0000_0000_0000_A5A5; result_valid pulses once; rand_req low the cycle after the word.
// - RDRAND_64, words 1111,2222,3333,4444:
//   - result = 64'h4444_3333_2222_1111; exactly 1 result_valid; busy low after DONE.
// - RDSEED_32, then a 3rd valid word on the next strobe:
//   - result = 64'h0000_0000_<w1>_<w0>; excess_err=1 and stays 1 until err_clr.
//   - err_clr pulse -> excess_err=0.
// - RDSEED_64, only 2 words then rand_valid held low:
//   - timeout_err pulses TIMEOUT_CYCLES cycles after the 2nd word; no result_valid; FSM back to IDLE.
// - rst asserted after the 1st of 4 words:
//   - all outputs 0 immediately; the next RDSEED_16 completes normally with word_cnt starting from 0.
// - Word strobe landing on the timer-expiry cycle:
//   - word accepted, no timeout_err; request completes.

Source files
------------

// File: rtl/rand_word_assembler.sv
// rand_word_assembler: collects TRNG words into a 16/32/64-bit result for the host.
// Optional RAND_ASM_STATS_EN adds saturating done/timeout/excess counters.
package le_types;
   typedef enum logic [2:0] {RDSEED_16, RDSEED_32, RDSEED_64, RDRAND_16, RDRAND_32, RDRAND_64} rand_req_t;
endpackage

module rand_word_assembler
   import le_types::*;
#(
   parameter int OUTPUT_WIDTH   = 16,
   parameter int MAX_WORDS      = 4,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                              ic_clk,
   input  logic                              rst,
   input  logic                              cpu_req,
   input  rand_req_t                         cpu_req_type,
   output logic                              rand_req,
   output rand_req_t                         rand_req_type,
   input  logic [OUTPUT_WIDTH-1:0]           rand_byte,
   input  logic                              rand_valid,
   input  logic                              slow_clk,
   output logic                              busy,
   output logic [OUTPUT_WIDTH*MAX_WORDS-1:0] result,
   output logic                              result_valid,
   output logic                              timeout_err,
   output logic                              excess_err,
   input  logic                              err_clr
`ifdef RAND_ASM_STATS_EN
   ,
   output logic [31:0]                       stat_done,
   output logic [31:0]                       stat_timeout,
   output logic [31:0]                       stat_excess
`endif
);
   localparam int CW = $clog2(MAX_WORDS + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES);
   localparam int RW = OUTPUT_WIDTH * MAX_WORDS;

   typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

   state_t          state_q, state_d;
   rand_req_t       type_q, type_d;
   logic [2:0]      sync_q, sync_d;
   logic [1:0]      vld_q, vld_d;
   logic            stb_q, stb_d;
   logic [CW-1:0]   tgt_q, tgt_d, cnt_q, cnt_d;
   logic [TW-1:0]   timer_q, timer_d;
   logic [RW-1:0]   result_q, result_d;
   logic            tout_q, tout_d, excess_q, excess_d;
   logic            acc;

   // sync_q[2] is the edge-detect flop, so the strobe fires once per slow_clk rise
   assign sync_d = {sync_q[1:0], slow_clk};
   assign stb_d  = sync_q[1] & ~sync_q[2];
   assign vld_d  = {vld_q[0], rand_valid};
   assign acc    = stb_q & vld_q[1];

   always_comb begin
      state_d  = state_q;
      type_d   = type_q;
      tgt_d    = tgt_q;
      cnt_d    = cnt_q;
      timer_d  = timer_q;
      result_d = result_q;
      tout_d   = 1'b0;
      excess_d = (acc && state_q != COLLECT) || (excess_q && !err_clr);
      case (state_q)
         IDLE:
            if (cpu_req) begin
               state_d  = COLLECT;
               type_d   = cpu_req_type;
               tgt_d    = (cpu_req_type inside {RDSEED_16, RDRAND_16}) ? CW'(1) :
                          (cpu_req_type inside {RDSEED_32, RDRAND_32}) ? CW'(2) : CW'(MAX_WORDS);
               cnt_d    = '0;
               timer_d  = '0;
               result_d = '0;
            end
         COLLECT:
            if (acc) begin
               for (int i = 0; i < MAX_WORDS; i++)
                  if (cnt_q == CW'(i)) result_d[i*OUTPUT_WIDTH +: OUTPUT_WIDTH] = rand_byte;
               cnt_d   = cnt_q + CW'(1);
               timer_d = '0;
               if (cnt_q + CW'(1) == tgt_q) state_d = DONE;
            end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
               tout_d  = 1'b1;
               state_d = IDLE;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge ic_clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         type_q   <= RDSEED_16;
         sync_q   <= '0;
         vld_q    <= '0;
         stb_q    <= 1'b0;
         tgt_q    <= '0;
         cnt_q    <= '0;
         timer_q  <= '0;
         result_q <= '0;
         tout_q   <= 1'b0;
         excess_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         type_q   <= type_d;
         sync_q   <= sync_d;
         vld_q    <= vld_d;
         stb_q    <= stb_d;
         tgt_q    <= tgt_d;
         cnt_q    <= cnt_d;
         timer_q  <= timer_d;
         result_q <= result_d;
         tout_q   <= tout_d;
         excess_q <= excess_d;
      end
   end

   assign rand_req      = state_q == COLLECT;
   assign busy          = state_q != IDLE;
   assign result_valid  = state_q == DONE;
   assign rand_req_type = type_q;
   assign result        = result_q;
   assign timeout_err   = tout_q;
   assign excess_err    = excess_q;

`ifdef RAND_ASM_STATS_EN
   logic [31:0] stat_done_q, stat_done_d, stat_timeout_q, stat_timeout_d, stat_excess_q, stat_excess_d;

   always_comb begin
      stat_done_d    = stat_done_q    + ((result_valid && stat_done_q != '1) ? 32'd1 : 32'd0);
      stat_timeout_d = stat_timeout_q + ((tout_q && stat_timeout_q != '1) ? 32'd1 : 32'd0);
      stat_excess_d  = stat_excess_q  + ((acc && state_q != COLLECT && stat_excess_q != '1) ? 32'd1 : 32'd0);
   end

   always_ff @(posedge ic_clk or posedge rst) begin
      if (rst) begin
         stat_done_q    <= '0;
         stat_timeout_q <= '0;
         stat_excess_q  <= '0;
      end else begin
         stat_done_q    <= stat_done_d;
         stat_timeout_q <= stat_timeout_d;
         stat_excess_q  <= stat_excess_d;
      end
   end

   assign stat_done    = stat_done_q;
   assign stat_timeout = stat_timeout_q;
   assign stat_excess  = stat_excess_q;
`endif
endmodule

// File: tb/tb_rand_word_assembler.sv
// tb_rand_word_assembler: vector table, random transactions vs. a word-list model, and timing corner sequences.
module tb_rand_word_assembler;
   import le_types::*;

   localparam int T = 64;

   logic        ic_clk = 1'b0, rst = 1'b1, cpu_req = 1'b0, rand_valid = 1'b0, slow_clk = 1'b0, err_clr = 1'b0;
   rand_req_t   cpu_req_type = RDSEED_16;
   rand_req_t   rand_req_type;
   logic [15:0] rand_byte = '0;
   logic        rand_req, busy, result_valid, timeout_err, excess_err;
   logic [63:0] result;
   int          errors = 0, checks = 0, rv_cnt = 0, to_cnt = 0;

   rand_word_assembler #(.OUTPUT_WIDTH(16), .MAX_WORDS(4), .TIMEOUT_CYCLES(T)) dut (
      .ic_clk(ic_clk), .rst(rst), .cpu_req(cpu_req), .cpu_req_type(cpu_req_type),
      .rand_req(rand_req), .rand_req_type(rand_req_type), .rand_byte(rand_byte),
      .rand_valid(rand_valid), .slow_clk(slow_clk), .busy(busy), .result(result),
      .result_valid(result_valid), .timeout_err(timeout_err), .excess_err(excess_err),
      .err_clr(err_clr)
`ifdef RAND_ASM_STATS_EN
      , .stat_done(), .stat_timeout(), .stat_excess()
`endif
   );

   always #5 ic_clk = ~ic_clk;

   always @(negedge ic_clk) begin
      if (result_valid) rv_cnt++;
      if (timeout_err) to_cnt++;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   typedef struct {
      string            name;
      rand_req_t        typ;
      int               n;
      logic [5:0][15:0] w;
      logic [5:0]       vm;
      logic [63:0]      exp_res;
      logic             exp_rv, exp_to, exp_ex;
   } vec_t;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic rise(input logic [15:0] w, input logic v);
      rand_byte = w;
      rand_valid = v;
      slow_clk = 1'b1;
   endtask

   task automatic send_word(input logic [15:0] w, input logic v, input logic poke);
      rise(w, v);
      @(negedge ic_clk);
      if (poke) begin
         cpu_req = 1'b1;
         cpu_req_type = RDSEED_16;
      end
      @(negedge ic_clk);
      cpu_req = 1'b0;
      repeat (2) @(negedge ic_clk);
      slow_clk = 1'b0;
      repeat (4) @(negedge ic_clk);
   endtask

   task automatic start(input rand_req_t t);
      err_clr = 1'b1;
      @(negedge ic_clk);
      err_clr = 1'b0;
      rv_cnt = 0;
      to_cnt = 0;
      cpu_req = 1'b1;
      cpu_req_type = t;
      @(negedge ic_clk);
      cpu_req = 1'b0;
   endtask

   // a cpu_req during the first word probes that requests are ignored while busy
   task automatic run_txn(input rand_req_t t, input int n, input logic [5:0][15:0] w, input logic [5:0] vm);
      start(t);
      for (int j = 0; j < n; j++) send_word(w[j], vm[j], j == 0);
      repeat (T + 20) @(negedge ic_clk);
   endtask

   task automatic check_txn(input string name, input rand_req_t t, input logic [63:0] er,
                            input logic erv, input logic eto, input logic eex);
      chk({name, " result"}, result, er);
      chk({name, " result_valid count"}, 64'(rv_cnt), {63'b0, erv});
      chk({name, " timeout count"}, 64'(to_cnt), {63'b0, eto});
      chk({name, " excess_err"}, 64'(excess_err), {63'b0, eex});
      chk({name, " busy"}, 64'(busy), 64'd0);
      chk({name, " req_type"}, 64'(rand_req_type), 64'(t));
   endtask

   function automatic int words_for(input rand_req_t t);
      if (t == RDSEED_16 || t == RDRAND_16) return 1;
      if (t == RDSEED_32 || t == RDRAND_32) return 2;
      return 4;
   endfunction

   vec_t tbl[6];

   initial begin
      tbl[0] = '{"seed16", RDSEED_16, 1, {16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'hA5A5}, 6'b000001,
                 64'h0000_0000_0000_A5A5, 1'b1, 1'b0, 1'b0};
      tbl[1] = '{"rand64", RDRAND_64, 4, {16'h0, 16'h0, 16'h4444, 16'h3333, 16'h2222, 16'h1111}, 6'b001111,
                 64'h4444_3333_2222_1111, 1'b1, 1'b0, 1'b0};
      tbl[2] = '{"seed32x3", RDSEED_32, 3, {16'h0, 16'h0, 16'h0, 16'h0F0F, 16'hCAFE, 16'hBEEF}, 6'b000111,
                 64'h0000_0000_CAFE_BEEF, 1'b1, 1'b0, 1'b1};
      tbl[3] = '{"seed64part", RDSEED_64, 2, {16'h0, 16'h0, 16'h0, 16'h0, 16'h5678, 16'h1234}, 6'b000011,
                 64'h0000_0000_5678_1234, 1'b0, 1'b1, 1'b0};
      tbl[4] = '{"rand32gap", RDRAND_32, 3, {16'h0, 16'h0, 16'h0, 16'hCCCC, 16'hBBBB, 16'hAAAA}, 6'b000101,
                 64'h0000_0000_CCCC_AAAA, 1'b1, 1'b0, 1'b0};
      tbl[5] = '{"rand16skip", RDRAND_16, 2, {16'h0, 16'h0, 16'h0, 16'h0, 16'h0002, 16'h0001}, 6'b000010,
                 64'h0000_0000_0000_0002, 1'b1, 1'b0, 1'b0};

      #1;
      chk("reset result", result, 64'd0);
      chk("reset rand_req", 64'(rand_req), 64'd0);
      chk("reset busy", 64'(busy), 64'd0);
      chk("reset result_valid", 64'(result_valid), 64'd0);
      chk("reset timeout_err", 64'(timeout_err), 64'd0);
      chk("reset excess_err", 64'(excess_err), 64'd0);
      repeat (3) @(negedge ic_clk);
      rst = 1'b0;
      @(negedge ic_clk);

      for (int i = 0; i < 6; i++) begin
         run_txn(tbl[i].typ, tbl[i].n, tbl[i].w, tbl[i].vm);
         check_txn(tbl[i].name, tbl[i].typ, tbl[i].exp_res, tbl[i].exp_rv, tbl[i].exp_to, tbl[i].exp_ex);
      end

      // rand_req must already be low in the result_valid cycle
      begin
         bit seen = 0;
         start(RDSEED_16);
         rise(16'hA5A5, 1'b1);
         for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge ic_clk);
            if (result_valid) begin
               seen = 1;
               chk("seed16 rand_req in done", 64'(rand_req), 64'd0);
               chk("seed16 result at valid", result, 64'h0000_0000_0000_A5A5);
            end
         end
         chk("seed16 valid seen", 64'(seen), 64'd1);
         @(negedge ic_clk);
         chk("seed16 busy after done", 64'(busy), 64'd0);
         slow_clk = 1'b0;
         repeat (10) @(negedge ic_clk);
      end

      // excess_err is sticky until err_clr
      run_txn(tbl[2].typ, tbl[2].n, tbl[2].w, tbl[2].vm);
      chk("excess sticky", 64'(excess_err), 64'd1);
      err_clr = 1'b1;
      @(negedge ic_clk);
      err_clr = 1'b0;
      @(negedge ic_clk);
      chk("excess cleared", 64'(excess_err), 64'd0);

      // timeout lands TIMEOUT_CYCLES after the word is accepted, 4 edges after its strobe rise
      begin
         int n = 0;
         bit seen = 0;
         start(RDSEED_64);
         send_word(16'h0101, 1'b1, 1'b0);
         rise(16'h0202, 1'b1);
         for (int k = 0; k < T + 20 && !seen; k++) begin
            @(posedge ic_clk);
            #1;
            n++;
            seen = timeout_err;
         end
         chk("timeout latency", 64'(n), 64'(T + 4));
         slow_clk = 1'b0;
         rand_valid = 1'b0;
         repeat (5) @(negedge ic_clk);
         chk("timeout partial result", result, 64'h0000_0000_0202_0101);
         chk("timeout no valid", 64'(rv_cnt), 64'd0);
         chk("timeout idle", 64'(busy), 64'd0);
      end

      // asynchronous reset mid-request
      start(RDRAND_64);
      send_word(16'h7777, 1'b1, 1'b0);
      rst = 1'b1;
      #1;
      chk("midrst result", result, 64'd0);
      chk("midrst rand_req", 64'(rand_req), 64'd0);
      chk("midrst busy", 64'(busy), 64'd0);
      @(negedge ic_clk);
      rst = 1'b0;
      @(negedge ic_clk);
      run_txn(RDSEED_16, 1, {16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h9999}, 6'b000001);
      check_txn("after rst", RDSEED_16, 64'h0000_0000_0000_9999, 1'b1, 1'b0, 1'b0);

      // strobes exactly T apart land the second word on the expiry cycle; T+1 apart misses it
      for (int gap = T; gap <= T + 1; gap++) begin
         start(RDSEED_32);
         rise(16'h00AB, 1'b1);
         repeat (4) @(negedge ic_clk);
         slow_clk = 1'b0;
         repeat (gap - 4) @(negedge ic_clk);
         rise(16'h00CD, 1'b1);
         repeat (4) @(negedge ic_clk);
         slow_clk = 1'b0;
         repeat (T + 20) @(negedge ic_clk);
         if (gap == T) check_txn("expiry word wins", RDSEED_32, 64'h0000_0000_00CD_00AB, 1'b1, 1'b0, 1'b0);
         else check_txn("expiry missed", RDSEED_32, 64'h0000_0000_0000_00AB, 1'b0, 1'b1, 1'b1);
      end

      for (int r = 0; r < 20; r++) begin
         rand_req_t        t;
         int               n, tgt, nv;
         logic [5:0][15:0] w;
         logic [5:0]       vm;
         logic [63:0]      er;
         t = rand_req_t'($urandom_range(0, 5));
         n = $urandom_range(0, 6);
         tgt = words_for(t);
         nv = 0;
         er = '0;
         for (int j = 0; j < 6; j++) begin
            w[j] = 16'($urandom);
            vm[j] = $urandom_range(0, 3) != 0;
            if (j < n && vm[j]) begin
               if (nv < tgt) er = er | (64'(w[j]) << (16 * nv));
               nv++;
            end
         end
         run_txn(t, n, w, vm);
         check_txn($sformatf("rand%0d", r), t, er, nv >= tgt, nv < tgt, nv > tgt);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
